// File: rtl/img_rsz_collector_if.sv
// Stream bundle between the resized-pixel forwarder, the collector and the output stage.
// The collector uses the slave modport; the producer/consumer side uses master.
interface img_rsz_collector_if #(
    parameter int PXL_W                = 24,
    parameter int RSZ_IMG_WIDTH_IDX_W  = 2,
    parameter int RSZ_IMG_HEIGHT_IDX_W = 2
);
    logic [PXL_W-1:0]                RszPxlData;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlX;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlY;
    logic                            RszPxlVld;
    logic                            RszPxlRdy;
    logic [PXL_W-1:0]                OutPxlData;
    logic                            OutPxlFirst;
    logic                            OutPxlLast;
    logic                            OutPxlVld;
    logic                            OutPxlRdy;
    logic                            FrmDone;
    logic                            DupErr;
    logic                            RngErr;

    modport slave (
        input  RszPxlData, RszPxlX, RszPxlY, RszPxlVld, OutPxlRdy,
        output RszPxlRdy, OutPxlData, OutPxlFirst, OutPxlLast, OutPxlVld,
               FrmDone, DupErr, RngErr
    );

    modport master (
        output RszPxlData, RszPxlX, RszPxlY, RszPxlVld, OutPxlRdy,
        input  RszPxlRdy, OutPxlData, OutPxlFirst, OutPxlLast, OutPxlVld,
               FrmDone, DupErr, RngErr
    );
endinterface

// File: rtl/img_rsz_collector.sv
// Reorder buffer that takes out-of-order resized pixels and re-emits them in raster order.
// Optional zero-latency pass-through of the pixel at the read pointer: define IMG_RSZ_COL_BYPASS_EN.
module img_rsz_collector #(
    parameter int RSZ_IMG_WIDTH_SIZE   = 4,
    parameter int RSZ_IMG_HEIGHT_SIZE  = 4,
    parameter int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    parameter int PXL_PRIM_COLOR_NUM   = 3,
    parameter int PXL_PRIM_COLOR_W     = 8,
    parameter int PXL_W                = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W
) (
    input logic                 Clk,
    input logic                 Rst,
    img_rsz_collector_if.slave  bus
);
    localparam int W      = RSZ_IMG_WIDTH_SIZE;
    localparam int H      = RSZ_IMG_HEIGHT_SIZE;
    localparam int SLOTS  = W * H;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_XW = (W > 1) ? $clog2(W) : 1;
    localparam int PTR_YW = (H > 1) ? $clog2(H) : 1;

    logic [PXL_W-1:0]  pxlBuf [SLOTS];
    logic [SLOTS-1:0]  slotFull;
    logic [PTR_XW-1:0] rdX;
    logic [PTR_YW-1:0] rdY;
    logic              frmDone;
    logic              dupErr;
    logic              rngErr;

    logic              inAcc;
    logic              wrInRange;
    logic [SLOT_W-1:0] wrSlot;
    logic [SLOT_W-1:0] rdSlot;
    logic              slotHit;
    logic              bypassHit;
    logic              outVld;
    logic              outXfer;
    logic              rdIsLast;
    logic              wrOk;
    logic              wrDup;
    logic              wrRng;

    // Slot indices are flattened raster positions; the write index is only used when in range.
    always_comb begin
        inAcc     = bus.RszPxlVld && !Rst;
        wrInRange = (int'(bus.RszPxlX) < W) && (int'(bus.RszPxlY) < H);
        wrSlot    = SLOT_W'(int'(bus.RszPxlY) * W + int'(bus.RszPxlX));
        rdSlot    = SLOT_W'(int'(rdY) * W + int'(rdX));
        slotHit   = slotFull[rdSlot];
`ifdef IMG_RSZ_COL_BYPASS_EN
        bypassHit = inAcc && wrInRange && !slotHit && (wrSlot == rdSlot);
`else
        bypassHit = 1'b0;
`endif
        outVld    = !Rst && (slotHit || bypassHit);
        outXfer   = outVld && bus.OutPxlRdy;
        rdIsLast  = (rdX == PTR_XW'(W - 1)) && (rdY == PTR_YW'(H - 1));
        wrOk      = inAcc && wrInRange && !slotFull[wrSlot] && !(bypassHit && bus.OutPxlRdy);
        wrDup     = inAcc && wrInRange && slotFull[wrSlot];
        wrRng     = inAcc && !wrInRange;
    end

    // A write can never hit the slot being drained: a drained slot is full, so the write is a duplicate.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            slotFull <= '0;
            rdX      <= '0;
            rdY      <= '0;
            frmDone  <= 1'b0;
            dupErr   <= 1'b0;
            rngErr   <= 1'b0;
        end else begin
            frmDone <= outXfer && rdIsLast;
            if (wrDup) dupErr <= 1'b1;
            if (wrRng) rngErr <= 1'b1;
            if (outXfer) slotFull[rdSlot] <= 1'b0;
            if (wrOk) slotFull[wrSlot] <= 1'b1;
            if (outXfer) begin
                if (rdX == PTR_XW'(W - 1)) begin
                    rdX <= '0;
                    if (rdY == PTR_YW'(H - 1)) rdY <= '0;
                    else                       rdY <= rdY + 1'b1;
                end else begin
                    rdX <= rdX + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wrOk) pxlBuf[wrSlot] <= bus.RszPxlData;
    end

    assign bus.RszPxlRdy   = !Rst;
    assign bus.OutPxlVld   = outVld;
    assign bus.OutPxlData  = bypassHit ? bus.RszPxlData : pxlBuf[rdSlot];
    assign bus.OutPxlFirst = (rdX == '0) && (rdY == '0);
    assign bus.OutPxlLast  = rdIsLast;
    assign bus.FrmDone     = frmDone;
    assign bus.DupErr      = dupErr;
    assign bus.RngErr      = rngErr;
endmodule

// File: tb/tb_img_rsz_collector.sv
// Self-checking bench for img_rsz_collector: raster, reverse, duplicate/hold, range and reset cases.
// Built with a 3-bit X index so that out-of-range columns can be presented.
module tb_img_rsz_collector;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int XIW   = 3;
    localparam int YIW   = 2;
    localparam int PXL_W = 24;

    logic Clk;
    logic Rst;
    int   compared;
    int   mismatched;

    img_rsz_collector_if #(.PXL_W(PXL_W), .RSZ_IMG_WIDTH_IDX_W(XIW), .RSZ_IMG_HEIGHT_IDX_W(YIW)) bus ();

    img_rsz_collector #(
        .RSZ_IMG_WIDTH_SIZE  (W),
        .RSZ_IMG_HEIGHT_SIZE (H),
        .RSZ_IMG_WIDTH_IDX_W (XIW),
        .RSZ_IMG_HEIGHT_IDX_W(YIW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct {
        logic             inVld;
        logic [XIW-1:0]   inX;
        logic [YIW-1:0]   inY;
        logic [PXL_W-1:0] inData;
        logic             expVld;
        logic [PXL_W-1:0] expData;
        logic             expFirst;
        logic             expLast;
        logic             expFrmDone;
    } vec_t;

    vec_t rasterTab [17];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic vld, input logic [XIW-1:0] x, input logic [YIW-1:0] y,
                                 input logic [PXL_W-1:0] data, input logic outRdy);
        bus.RszPxlVld  = vld;
        bus.RszPxlX    = x;
        bus.RszPxlY    = y;
        bus.RszPxlData = data;
        bus.OutPxlRdy  = outRdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    // Raster input with OutPxlRdy=1; rows hold base values, offset distinguishes frames.
    task automatic runRaster(input logic [PXL_W-1:0] offset);
        for (int k = 0; k < 17; k++) begin
            nextCycle();
            applyStimulus(rasterTab[k].inVld, rasterTab[k].inX, rasterTab[k].inY,
                          rasterTab[k].inData + offset, 1'b1);
            @(negedge Clk);
            checkOutput($sformatf("raster[%0d].vld", k), 32'(bus.OutPxlVld), 32'(rasterTab[k].expVld));
            checkOutput($sformatf("raster[%0d].frmDone", k), 32'(bus.FrmDone), 32'(rasterTab[k].expFrmDone));
            if (rasterTab[k].expVld) begin
                checkOutput($sformatf("raster[%0d].data", k), 32'(bus.OutPxlData),
                            32'(rasterTab[k].expData + offset));
                checkOutput($sformatf("raster[%0d].first", k), 32'(bus.OutPxlFirst), 32'(rasterTab[k].expFirst));
                checkOutput($sformatf("raster[%0d].last", k), 32'(bus.OutPxlLast), 32'(rasterTab[k].expLast));
            end
        end
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        @(negedge Clk);
        checkOutput("raster.frmDonePulse", 32'(bus.FrmDone), 32'd1);
        checkOutput("raster.emptyAfter", 32'(bus.OutPxlVld), 32'd0);
        nextCycle();
        @(negedge Clk);
        checkOutput("raster.frmDoneDrop", 32'(bus.FrmDone), 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Row k writes pixel k; the pixel written one row earlier is on the output.
        for (int k = 0; k < 17; k++) begin
            rasterTab[k].inVld      = (k < 16);
            rasterTab[k].inX        = XIW'(k % W);
            rasterTab[k].inY        = YIW'((k / W) % H);
            rasterTab[k].inData     = PXL_W'(k);
            rasterTab[k].expVld     = (k > 0);
            rasterTab[k].expData    = PXL_W'(k - 1);
            rasterTab[k].expFirst   = (k == 1);
            rasterTab[k].expLast    = (k == 16);
            rasterTab[k].expFrmDone = 1'b0;
        end

        Rst = 1'b1;
        applyStimulus(1'b1, 3'd0, 2'd0, 24'h123456, 1'b1);
        @(negedge Clk);
        checkOutput("reset.rszRdy", 32'(bus.RszPxlRdy), 32'd0);
        checkOutput("reset.outVld", 32'(bus.OutPxlVld), 32'd0);
        nextCycle();
        nextCycle();
        Rst = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        @(negedge Clk);
        checkOutput("init.rszRdy", 32'(bus.RszPxlRdy), 32'd1);
        checkOutput("init.outVld", 32'(bus.OutPxlVld), 32'd0);
        checkOutput("init.frmDone", 32'(bus.FrmDone), 32'd0);
        checkOutput("init.dupErr", 32'(bus.DupErr), 32'd0);
        checkOutput("init.rngErr", 32'(bus.RngErr), 32'd0);

        $display("[TB] raster frame");
        runRaster(24'h000000);

        $display("[TB] reverse-order frame");
        for (int i = 15; i >= 0; i--) begin
            nextCycle();
            applyStimulus(1'b1, XIW'(i % W), YIW'(i / W), 24'h200 + 24'(i), 1'b1);
            @(negedge Clk);
            checkOutput($sformatf("reverse.wait[%0d]", i), 32'(bus.OutPxlVld), 32'd0);
        end
        for (int k = 0; k < 16; k++) begin
            nextCycle();
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            @(negedge Clk);
            checkOutput($sformatf("reverse.vld[%0d]", k), 32'(bus.OutPxlVld), 32'd1);
            checkOutput($sformatf("reverse.data[%0d]", k), 32'(bus.OutPxlData), 32'h200 + 32'(k));
        end
        nextCycle();
        @(negedge Clk);
        checkOutput("reverse.frmDone", 32'(bus.FrmDone), 32'd1);

        // Fill with the output stalled: slot (0,0) must hold while (1,2) is written twice.
        $display("[TB] duplicate write and output hold");
        for (int s = 0; s < 17; s++) begin
            int slot;
            logic [PXL_W-1:0] d;
            slot = (s < 10) ? s : ((s == 10) ? 9 : s - 1);
            d    = (s == 9) ? 24'hAA : ((s == 10) ? 24'h55 : 24'h300 + 24'(slot));
            nextCycle();
            applyStimulus(1'b1, XIW'(slot % W), YIW'(slot / W), d, 1'b0);
            @(negedge Clk);
            checkOutput($sformatf("hold.dupErr[%0d]", s), 32'(bus.DupErr), 32'(s >= 11));
            if (s >= 1) begin
                checkOutput($sformatf("hold.vld[%0d]", s), 32'(bus.OutPxlVld), 32'd1);
                checkOutput($sformatf("hold.data[%0d]", s), 32'(bus.OutPxlData), 32'h300);
            end
        end
        for (int k = 0; k < 16; k++) begin
            nextCycle();
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            @(negedge Clk);
            checkOutput($sformatf("drain.vld[%0d]", k), 32'(bus.OutPxlVld), 32'd1);
            checkOutput($sformatf("drain.data[%0d]", k), 32'(bus.OutPxlData),
                        (k == 9) ? 32'hAA : 32'h300 + 32'(k));
            checkOutput($sformatf("drain.first[%0d]", k), 32'(bus.OutPxlFirst), 32'(k == 0));
            checkOutput($sformatf("drain.last[%0d]", k), 32'(bus.OutPxlLast), 32'(k == 15));
        end
        nextCycle();
        @(negedge Clk);
        checkOutput("drain.frmDone", 32'(bus.FrmDone), 32'd1);
        checkOutput("drain.dupErrSticky", 32'(bus.DupErr), 32'd1);

        $display("[TB] out-of-range index");
        nextCycle();
        applyStimulus(1'b1, 3'd4, 2'd0, 24'h77, 1'b1);
        @(negedge Clk);
        checkOutput("range.rngErrBefore", 32'(bus.RngErr), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 3'd7, 2'd3, 24'h78, 1'b1);
        @(negedge Clk);
        checkOutput("range.rngErr", 32'(bus.RngErr), 32'd1);
        checkOutput("range.noSlot", 32'(bus.OutPxlVld), 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        @(negedge Clk);
        checkOutput("range.noSlotLater", 32'(bus.OutPxlVld), 32'd0);
        checkOutput("range.rngErrSticky", 32'(bus.RngErr), 32'd1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 7; i++) begin
            nextCycle();
            applyStimulus(1'b1, XIW'(i % W), YIW'(i / W), 24'h400 + 24'(i), 1'b0);
        end
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        @(negedge Clk);
        checkOutput("abort.vldBefore", 32'(bus.OutPxlVld), 32'd1);
        checkOutput("abort.dataBefore", 32'(bus.OutPxlData), 32'h400);
        nextCycle();
        Rst = 1'b1;
        applyStimulus(1'b1, 3'd0, 2'd2, 24'h55, 1'b1);
        @(negedge Clk);
        checkOutput("abort.rszRdy", 32'(bus.RszPxlRdy), 32'd0);
        checkOutput("abort.outVld", 32'(bus.OutPxlVld), 32'd0);
        nextCycle();
        Rst = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        @(negedge Clk);
        checkOutput("abort.vldAfter", 32'(bus.OutPxlVld), 32'd0);
        checkOutput("abort.dupErr", 32'(bus.DupErr), 32'd0);
        checkOutput("abort.rngErr", 32'(bus.RngErr), 32'd0);
        checkOutput("abort.frmDone", 32'(bus.FrmDone), 32'd0);
        nextCycle();
        @(negedge Clk);
        checkOutput("abort.vldLater", 32'(bus.OutPxlVld), 32'd0);
        runRaster(24'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
